// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch -- instruction-fetch unit between the PC register and IF/ID.
//
// Issues one read at a time on the instruction bus for the current PC and
// hands the returned word to IF/ID. While a fetch is in flight it raises
// hold_req_o so the PC holds until the word arrives. A jump squashes the
// in-flight fetch so wrong-path words never reach decode.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   pc_i            current PC
//   jump_flag_i     jump taken this cycle
//   hold_flag_i     ctrl stall level (0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id)
//   ibus_*          single-outstanding read bus (req/addr out, gnt/rvalid/rdata in)
//   inst_o          instruction to IF/ID (NOP_INST when bubble)
//   inst_addr_o     address of inst_o
//   inst_valid_o    inst_o is a real fetched word
//   hold_req_o      stall request to ctrl (Hold_Pc)
//   fetch_err_o     one-cycle timeout fault
//
// Optional feature: define IFU_TIMEOUT_EN to enable the fetch timeout counter.
// Without it fetch_err_o is tied low and the FSM waits indefinitely.
//
// Outside a Hold_If/Hold_Id stall a fetched word is shown for exactly one
// cycle; afterwards the outputs fall back to a bubble until the next word.
// ----------------------------------------------------------------------------
module ifu_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013,
    parameter logic [ADDR_W-1:0] RST_ADDR = 32'h00000000,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_flag_i,
    input  logic [2:0]        hold_flag_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              hold_req_o,
    output logic              fetch_err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_inst;
    logic [ADDR_W-1:0]   r_inst_addr;
    logic                r_inst_valid;
    // One-entry skid for a word that lands while IF/ID is stalled.
    logic                r_skid_valid;
    logic [DATA_W-1:0]   r_skid_data;
    logic [ADDR_W-1:0]   r_skid_addr;

    logic                w_hold_if;

    assign w_hold_if = (hold_flag_i >= 3'd2);

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_tmo;

    assign w_tmo       = (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign fetch_err_o = r_err;
`else
    assign fetch_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_inst       <= NOP_INST;
            r_inst_addr  <= RST_ADDR;
            r_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_addr  <= '0;
`ifdef IFU_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            // Default: a shown word lasts one cycle unless IF/ID is stalled.
            if (!w_hold_if) begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
`ifdef IFU_TIMEOUT_EN
            r_err <= 1'b0;
            if (r_state == StReq || r_state == StWait) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
`endif
            unique case (r_state)
                StIdle: begin
                    if (jump_flag_i) begin
                        // Skid word is younger than the jump: wrong path.
                        r_skid_valid <= 1'b0;
                    end else if (!w_hold_if) begin
                        if (r_skid_valid) begin
                            r_inst       <= r_skid_data;
                            r_inst_addr  <= r_skid_addr;
                            r_inst_valid <= 1'b1;
                            r_skid_valid <= 1'b0;
                        end
                        r_state <= StReq;
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
`ifdef IFU_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                StReq: begin
                    if (jump_flag_i) begin
                        r_req   <= 1'b0;
                        r_state <= ibus_gnt_i ? StDrain : StIdle;
`ifdef IFU_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_req        <= 1'b0;
                        r_err        <= 1'b1;
                        r_inst       <= NOP_INST;
                        r_inst_valid <= 1'b0;
                        r_state      <= ibus_gnt_i ? StDrain : StIdle;
`endif
                    end else if (ibus_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (jump_flag_i) begin
                        r_state <= ibus_rvalid_i ? StIdle : StDrain;
                    end else if (ibus_rvalid_i) begin
                        if (w_hold_if) begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= ibus_rdata_i;
                            r_skid_addr  <= r_addr;
                            r_state      <= StIdle;
                        end else begin
                            // Capture and launch the next fetch on the same edge.
                            r_inst       <= ibus_rdata_i;
                            r_inst_addr  <= r_addr;
                            r_inst_valid <= 1'b1;
                            r_state      <= StReq;
                            r_req        <= 1'b1;
                            r_addr       <= pc_i;
`ifdef IFU_TIMEOUT_EN
                            r_tmo_cnt    <= '0;
`endif
                        end
`ifdef IFU_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_err        <= 1'b1;
                        r_inst       <= NOP_INST;
                        r_inst_valid <= 1'b0;
                        r_state      <= StDrain;
`endif
                    end
                end
                StDrain: begin
                    // Granted read still owes a response; swallow it.
                    if (ibus_rvalid_i) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (jump_flag_i) begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
        end
    end

    // Combinational so the PC advances on the same edge that captures data.
    assign hold_req_o   = (r_state == StReq) || ((r_state == StWait) && !ibus_rvalid_i);
    assign ibus_req_o   = r_req;
    assign ibus_addr_o  = r_addr;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_flag_i;
    logic [2:0]  hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        hold_req_o;
    logic        fetch_err_o;

    localparam logic [31:0] NOP = 32'h00000013;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NOP_INST(32'h00000013),
        .RST_ADDR(32'h00000000),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .jump_flag_i  (jump_flag_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .hold_req_o   (hold_req_o),
        .fetch_err_o  (fetch_err_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        jump;
        logic [2:0]  hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_ia;
        logic        e_v;
        logic        e_hr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] pc, input logic j, input logic [2:0] h,
                       input logic g, input logic rv, input logic [31:0] rd,
                       input logic er, input logic [31:0] ea, input logic [31:0] ei,
                       input logic [31:0] eia, input logic ev, input logic ehr);
        vec_t v;
        v.pc = pc; v.jump = j; v.hold = h; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_ia = eia; v.e_v = ev; v.e_hr = ehr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic j, input logic [2:0] h,
                         input logic g, input logic rv, input logic [31:0] rd);
        pc_i = pc; jump_flag_i = j; hold_flag_i = h;
        ibus_gnt_i = g; ibus_rvalid_i = rv; ibus_rdata_i = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_req", {31'b0, ibus_req_o}, 32'd0);
        chk("rst_addr", ibus_addr_o, 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_inst_addr", inst_addr_o, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_hold_req", {31'b0, hold_req_o}, 32'd0);
        chk("rst_err", {31'b0, fetch_err_o}, 32'd0);
        rst = 1'b0;

        //   pc     j  h  g  rv rdata           req addr    inst          ia     v  hr
        add(32'h000, 0, 0, 0, 0, 32'h0,          0, 32'h000, NOP,          32'h0, 0, 0);
        add(32'h000, 0, 0, 1, 0, 32'h0,          1, 32'h000, NOP,          32'h0, 0, 1);
        add(32'h004, 0, 0, 0, 1, 32'h00100093,   0, 32'h000, NOP,          32'h0, 0, 0);
        add(32'h004, 0, 0, 1, 0, 32'h0,          1, 32'h004, 32'h00100093, 32'h0, 1, 1);
        add(32'h004, 0, 0, 0, 0, 32'h0,          0, 32'h004, NOP,          32'h0, 0, 1);
        add(32'h004, 0, 0, 0, 0, 32'h0,          0, 32'h004, NOP,          32'h0, 0, 1);
        add(32'h004, 0, 0, 0, 0, 32'h0,          0, 32'h004, NOP,          32'h0, 0, 1);
        add(32'h008, 0, 0, 0, 1, 32'h00200113,   0, 32'h004, NOP,          32'h0, 0, 0);
        add(32'h008, 0, 0, 1, 0, 32'h0,          1, 32'h008, 32'h00200113, 32'h4, 1, 1);
        add(32'h100, 1, 0, 0, 0, 32'h0,          0, 32'h008, NOP,          32'h4, 0, 1);
        add(32'h100, 0, 0, 0, 1, 32'hdeadbeef,   0, 32'h008, NOP,          32'h4, 0, 0);
        add(32'h100, 0, 0, 0, 0, 32'h0,          0, 32'h008, NOP,          32'h4, 0, 0);
        add(32'h100, 0, 0, 1, 0, 32'h0,          1, 32'h100, NOP,          32'h4, 0, 1);
        add(32'h00c, 0, 0, 0, 1, 32'h00300193,   0, 32'h100, NOP,          32'h4, 0, 0);
        add(32'h00c, 0, 3, 1, 0, 32'h0,          1, 32'h00c, 32'h00300193, 32'h100, 1, 1);
        add(32'h010, 0, 3, 0, 1, 32'h00400213,   0, 32'h00c, 32'h00300193, 32'h100, 1, 0);
        add(32'h010, 0, 3, 0, 0, 32'h0,          0, 32'h00c, 32'h00300193, 32'h100, 1, 0);
        add(32'h010, 0, 3, 0, 0, 32'h0,          0, 32'h00c, 32'h00300193, 32'h100, 1, 0);
        add(32'h010, 0, 3, 0, 0, 32'h0,          0, 32'h00c, 32'h00300193, 32'h100, 1, 0);
        add(32'h010, 0, 0, 0, 0, 32'h0,          0, 32'h00c, 32'h00300193, 32'h100, 1, 0);
        add(32'h010, 0, 0, 0, 0, 32'h0,          1, 32'h010, 32'h00400213, 32'h00c, 1, 1);
        add(32'h200, 1, 0, 0, 0, 32'h0,          1, 32'h010, NOP,          32'h00c, 0, 1);
        add(32'h200, 1, 0, 0, 0, 32'h0,          0, 32'h010, NOP,          32'h00c, 0, 0);
        add(32'h200, 0, 0, 0, 0, 32'h0,          0, 32'h010, NOP,          32'h00c, 0, 0);
        add(32'h300, 1, 0, 1, 0, 32'h0,          1, 32'h200, NOP,          32'h00c, 0, 1);
        add(32'h300, 1, 0, 0, 0, 32'h0,          0, 32'h200, NOP,          32'h00c, 0, 0);
        add(32'h300, 0, 0, 0, 1, 32'h00000bad,   0, 32'h200, NOP,          32'h00c, 0, 0);
        add(32'h300, 0, 0, 0, 0, 32'h0,          0, 32'h200, NOP,          32'h00c, 0, 0);
        add(32'h300, 0, 0, 1, 0, 32'h0,          1, 32'h300, NOP,          32'h00c, 0, 1);
        add(32'h400, 1, 0, 0, 1, 32'h00000055,   0, 32'h300, NOP,          32'h00c, 0, 0);
        add(32'h400, 0, 0, 0, 0, 32'h0,          0, 32'h300, NOP,          32'h00c, 0, 0);
        add(32'h400, 0, 0, 1, 0, 32'h0,          1, 32'h400, NOP,          32'h00c, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].jump, vecs[i].hold, vecs[i].gnt, vecs[i].rv,
                  vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, ibus_req_o}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), ibus_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_inst", i), inst_o, vecs[i].e_inst);
            chk($sformatf("v%0d_inst_addr", i), inst_addr_o, vecs[i].e_ia);
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].e_v});
            chk($sformatf("v%0d_hold_req", i), {31'b0, hold_req_o}, {31'b0, vecs[i].e_hr});
            chk($sformatf("v%0d_err", i), {31'b0, fetch_err_o}, 32'd0);
            tick();
        end

        // Reset while in WAIT, then a late rvalid arrives in IDLE.
        rst = 1'b1;
        drive(32'h500, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        drive(32'h500, 1'b0, 3'd2, 1'b0, 1'b1, 32'h00000077);
        #1;
        chk("late_rv_hold_req", {31'b0, hold_req_o}, 32'd0);
        chk("late_rv_req", {31'b0, ibus_req_o}, 32'd0);
        tick();
        drive(32'h500, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0);
        #1;
        chk("late_rv_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("late_rv_inst", inst_o, NOP);
        chk("late_rv_inst_addr", inst_addr_o, 32'h0);
        chk("late_rv_addr", ibus_addr_o, 32'h0);
        chk("late_rv_req2", {31'b0, ibus_req_o}, 32'd0);
        tick();

        // Responder never grants.
        drive(32'h600, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
`ifdef IFU_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("tmo_req_%0d", k), {31'b0, ibus_req_o}, 32'd1);
            chk($sformatf("tmo_err_%0d", k), {31'b0, fetch_err_o}, 32'd0);
        end
        hold_flag_i = 3'd2;
        tick();
        chk("tmo_err_pulse", {31'b0, fetch_err_o}, 32'd1);
        chk("tmo_req_drop", {31'b0, ibus_req_o}, 32'd0);
        chk("tmo_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("tmo_inst", inst_o, NOP);
        chk("tmo_hold_req", {31'b0, hold_req_o}, 32'd0);
        tick();
        chk("tmo_err_clear", {31'b0, fetch_err_o}, 32'd0);
        chk("tmo_idle", {31'b0, ibus_req_o}, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("nogrant_req_%0d", k), {31'b0, ibus_req_o}, 32'd1);
            chk($sformatf("nogrant_err_%0d", k), {31'b0, fetch_err_o}, 32'd0);
        end
        chk("nogrant_addr", ibus_addr_o, 32'h600);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch responder to the PC register: takes the current PC, issues a single-outstanding read on the instruction bus, and returns the fetched word to the IF/ID stage.
- Raises a stall request toward ctrl while a fetch is in flight, so the PC holds until the word arrives.
- Squashes in-flight fetches on a jump, so wrong-path instructions never reach decode.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
NOP_INST, 32'h00000013, bubble injected on reset/flush (addi x0,x0,0)
RST_ADDR, 32'h00000000, inst_addr_o value after reset
TIMEOUT, 255, max cycles waiting for grant+data before fault (used only with IFU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc_i  in  ADDR_W  current PC from pc register
jump_flag_i  in  1  jump taken this cycle (same signal the PC consumes)
hold_flag_i  in  3  ctrl stall level: 0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id
ibus_req_o  out  1  read request, held until ibus_gnt_i
ibus_addr_o  out  ADDR_W  read address, stable while ibus_req_o=1
ibus_gnt_i  in  1  request accepted this cycle
ibus_rvalid_i  in  1  read data valid
ibus_rdata_i  in  DATA_W  read data
inst_o  out  DATA_W  instruction to IF/ID
inst_addr_o  out  ADDR_W  address of inst_o
inst_valid_o  out  1  inst_o is a real fetched instruction (0 = bubble)
hold_req_o  out  1  stall request to ctrl (maps to Hold_Pc)
fetch_err_o  out  1  sticky-per-fetch timeout fault (tied 0 without IFU_TIMEOUT_EN)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; ibus_req_o=0; ibus_addr_o=0; inst_o=NOP_INST; inst_addr_o=RST_ADDR; inst_valid_o=0; hold_req_o=0; fetch_err_o=0; drain flag cleared. Reset mid-fetch abandons the transaction; a late rvalid after reset is ignored because it arrives in IDLE.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: if hold_flag_i<2 and jump_flag_i=0: latch pc_i into ibus_addr_o, assert ibus_req_o, go REQ. Otherwise stay.
- REQ: ibus_req_o=1, address stable. On ibus_gnt_i: deassert req next cycle, go WAIT.
- WAIT: on ibus_rvalid_i: register inst_o=ibus_rdata_i, inst_addr_o=ibus_addr_o, inst_valid_o=1; go IDLE and, if the launch conditions hold, immediately launch the next fetch at pc_i (back-to-back; 2 cycles/inst minimum with zero-wait responder).
- hold_req_o=1 in REQ and WAIT, except in the WAIT cycle where ibus_rvalid_i=1. It is combinational from state and rvalid, so the PC advances on the same edge that captures data.
- Jump: jump_flag_i=1 in REQ before grant: drop req, go IDLE. In REQ with gnt, or in WAIT without rvalid: go DRAIN. In WAIT with rvalid: discard the data. In all cases, next posedge: inst_o=NOP_INST, inst_valid_o=0. Jump in IDLE: no launch that cycle; outputs become bubble.
- DRAIN: hold_req_o=0; ibus_req_o=0; wait for ibus_rvalid_i, discard data, go IDLE. A jump during DRAIN stays DRAIN.
- hold_flag_i>=2 (Hold_If/Hold_Id): inst_o/inst_addr_o/inst_valid_o keep their values; no new launch from IDLE. An in-flight fetch completes, but its result is held in a 1-entry skid register and presented once hold_flag_i<2. Do not lose it. hold_req_o stays 0 while a skid word is pending.
- hold_flag_i=1 alone: does not block the IFU.
- Exactly one outstanding transaction; ibus_rvalid_i in IDLE/REQ is protocol error, ignored.

Optional Feature:
- Macro IFU_TIMEOUT_EN.
- Defined: counter resets on entry to REQ, increments in REQ/WAIT. When it reaches TIMEOUT: fetch_err_o=1 for one cycle, inst_o=NOP_INST, inst_valid_o=0, go DRAIN if granted else IDLE.
- Undefined: no counter; fetch_err_o tied 0; FSM waits indefinitely.

Test Plan:
- Reset then pc_i=0x0, zero-wait responder (gnt same cycle as req, rvalid next) returning 0x00100093 -> inst_o=0x00100093, inst_addr_o=0x0, inst_valid_o=1 two cycles after launch; hold_req_o high exactly 1 cycle.
- Responder adds 3 wait cycles before rvalid -> hold_req_o=1 for 4 cycles, pc_i unchanged, single ibus_req_o handshake at 0x4.
- Jump asserted in WAIT at addr 0x8 -> rdata for 0x8 discarded, inst_valid_o=0 with inst_o=0x00000013, next request address equals new pc_i (e.g. 0x100).
- hold_flag_i=3 for 5 cycles during fetch of 0xC -> inst_o frozen; 0xC word emitted the cycle after hold drops; no second request issued meanwhile.
- rst asserted while in WAIT, late rvalid arrives next cycle -> outputs remain reset values, no inst_valid_o pulse.
- IFU_TIMEOUT_EN, TIMEOUT=8, responder never grants -> fetch_err_o pulses 1 cycle after 8 REQ cycles; inst_valid_o=0; IFU returns to IDLE.
